// File: rtl/bus_master_interface.sv
// Initiator endpoint for the shared Yutorina bus.
// Turns a one-cycle CPU access into request/grant, strobe and ready.
module bus_master_interface #(
  parameter int ADDRESS_WIDTH = 30,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_request,
  input  logic                     cpu_read_write,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0]    cpu_write_data,
  output logic                     cpu_busy,
  output logic                     cpu_done,
  output logic                     cpu_error,
  output logic [DATA_WIDTH-1:0]    cpu_read_data,
  output logic                     master_request_,
  input  logic                     master_grant_,
  output logic [ADDRESS_WIDTH-1:0] master_address,
  output logic                     master_address_strobe_,
  output logic                     master_read_write,
  output logic [DATA_WIDTH-1:0]    master_write_data,
  input  logic [DATA_WIDTH-1:0]    master_read_data,
  input  logic                     master_ready_
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_WAIT    = 2'd3;

  logic [1:0]               state;
  logic [CW-1:0]            counter;
  logic [ADDRESS_WIDTH-1:0] lat_address;
  logic                     lat_read_write;
  logic [DATA_WIDTH-1:0]    lat_write_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= ST_IDLE;
      counter                <= '0;
      lat_address            <= '0;
      lat_read_write         <= 1'b1;
      lat_write_data         <= '0;
      cpu_busy               <= 1'b0;
      cpu_done               <= 1'b0;
      cpu_error              <= 1'b0;
      cpu_read_data          <= '0;
      master_request_        <= 1'b1;
      master_address         <= '0;
      master_address_strobe_ <= 1'b1;
      master_read_write      <= 1'b1;
      master_write_data      <= '0;
    end else begin
      cpu_done  <= 1'b0;
      cpu_error <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cpu_request) begin
            lat_address     <= cpu_address;
            lat_read_write  <= cpu_read_write;
            lat_write_data  <= cpu_write_data;
            master_request_ <= 1'b0;
            cpu_busy        <= 1'b1;
            state           <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (!master_grant_) begin
            master_address         <= lat_address;
            master_read_write      <= lat_read_write;
            master_write_data      <= lat_write_data;
            master_address_strobe_ <= 1'b0;
            counter                <= CW'(1);
            state                  <= ST_ACCESS;
          end
        end
        ST_ACCESS, ST_WAIT: begin
          master_address_strobe_ <= 1'b1;
          // ready wins over timeout when both land on the same cycle
          if (!master_ready_ || counter == TIMEOUT_C) begin
            cpu_done          <= 1'b1;
            cpu_busy          <= 1'b0;
            master_request_   <= 1'b1;
            master_address    <= '0;
            master_read_write <= 1'b1;
            master_write_data <= '0;
            counter           <= '0;
            state             <= ST_IDLE;
            if (!master_ready_) begin
              if (lat_read_write) cpu_read_data <= master_read_data;
            end else begin
              cpu_error <= 1'b1;
            end
          end else begin
            counter <= counter + 1'b1;
            state   <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_interface.sv
// Directed bench for bus_master_interface.
// Bench acts as arbiter and slave; TIMEOUT is 4.
module tb_bus_master_interface;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_request = 1'b0;
  logic        cpu_read_write = 1'b1;
  logic [29:0] cpu_address = '0;
  logic [31:0] cpu_write_data = '0;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_error;
  logic [31:0] cpu_read_data;
  logic        master_request_;
  logic        master_grant_ = 1'b1;
  logic [29:0] master_address;
  logic        master_address_strobe_;
  logic        master_read_write;
  logic [31:0] master_write_data;
  logic [31:0] master_read_data = '0;
  logic        master_ready_ = 1'b1;

  int checks = 0;
  int failures = 0;
  int dones = 0;

  bus_master_interface #(
    .ADDRESS_WIDTH(30),
    .DATA_WIDTH(32),
    .TIMEOUT(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_request(cpu_request),
    .cpu_read_write(cpu_read_write),
    .cpu_address(cpu_address),
    .cpu_write_data(cpu_write_data),
    .cpu_busy(cpu_busy),
    .cpu_done(cpu_done),
    .cpu_error(cpu_error),
    .cpu_read_data(cpu_read_data),
    .master_request_(master_request_),
    .master_grant_(master_grant_),
    .master_address(master_address),
    .master_address_strobe_(master_address_strobe_),
    .master_read_write(master_read_write),
    .master_write_data(master_write_data),
    .master_read_data(master_read_data),
    .master_ready_(master_ready_)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_req", 32'(master_request_), 32'h1);
    chk("rst_stb", 32'(master_address_strobe_), 32'h1);
    chk("rst_rw", 32'(master_read_write), 32'h1);
    chk("rst_addr", 32'(master_address), 32'h0);
    chk("rst_wd", master_write_data, 32'h0);
    chk("rst_busy", 32'(cpu_busy), 32'h0);
    chk("rst_done", 32'(cpu_done), 32'h0);
    chk("rst_err", 32'(cpu_error), 32'h0);
    chk("rst_rd", cpu_read_data, 32'h0);
    reset = 1'b0;

    // 1: minimum-latency read
    cpu_request = 1'b1;
    cpu_read_write = 1'b1;
    cpu_address = 30'h55;
    step();
    chk("t1_req", 32'(master_request_), 32'h0);
    chk("t1_busy", 32'(cpu_busy), 32'h1);
    chk("t1_stb_req", 32'(master_address_strobe_), 32'h1);
    chk("t1_addr_req", 32'(master_address), 32'h0);
    cpu_request = 1'b0;
    master_grant_ = 1'b0;
    master_ready_ = 1'b0;
    master_read_data = 32'hDEADBEEF;
    step();
    chk("t1_stb", 32'(master_address_strobe_), 32'h0);
    chk("t1_addr", 32'(master_address), 32'h55);
    chk("t1_rw", 32'(master_read_write), 32'h1);
    chk("t1_done_early", 32'(cpu_done), 32'h0);
    step();
    chk("t1_done", 32'(cpu_done), 32'h1);
    chk("t1_err", 32'(cpu_error), 32'h0);
    chk("t1_rd", cpu_read_data, 32'hDEADBEEF);
    chk("t1_req_rel", 32'(master_request_), 32'h1);
    chk("t1_stb_rel", 32'(master_address_strobe_), 32'h1);
    chk("t1_busy_rel", 32'(cpu_busy), 32'h0);
    chk("t1_addr_rel", 32'(master_address), 32'h0);
    master_grant_ = 1'b1;
    master_ready_ = 1'b1;
    master_read_data = 32'h0;
    step();
    chk("t1_done_pulse", 32'(cpu_done), 32'h0);
    chk("t1_rd_hold", cpu_read_data, 32'hDEADBEEF);

    // 2: write with three wait states
    cpu_request = 1'b1;
    cpu_read_write = 1'b0;
    cpu_address = 30'h100;
    cpu_write_data = 32'h12345678;
    step();
    chk("t2_req", 32'(master_request_), 32'h0);
    cpu_request = 1'b0;
    master_grant_ = 1'b0;
    step();
    chk("t2_stb", 32'(master_address_strobe_), 32'h0);
    chk("t2_addr_a", 32'(master_address), 32'h100);
    chk("t2_wd_a", master_write_data, 32'h12345678);
    chk("t2_rw_a", 32'(master_read_write), 32'h0);
    master_grant_ = 1'b1;
    step();
    chk("t2_stb_w1", 32'(master_address_strobe_), 32'h1);
    chk("t2_addr_w1", 32'(master_address), 32'h100);
    chk("t2_wd_w1", master_write_data, 32'h12345678);
    chk("t2_rw_w1", 32'(master_read_write), 32'h0);
    step();
    chk("t2_addr_w2", 32'(master_address), 32'h100);
    chk("t2_rw_w2", 32'(master_read_write), 32'h0);
    step();
    chk("t2_addr_w3", 32'(master_address), 32'h100);
    chk("t2_wd_w3", master_write_data, 32'h12345678);
    chk("t2_req_w3", 32'(master_request_), 32'h0);
    chk("t2_done_w3", 32'(cpu_done), 32'h0);
    master_ready_ = 1'b0;
    master_read_data = 32'hAAAA5555;
    step();
    chk("t2_done", 32'(cpu_done), 32'h1);
    chk("t2_err", 32'(cpu_error), 32'h0);
    chk("t2_rd_keep", cpu_read_data, 32'hDEADBEEF);
    chk("t2_wd_rel", master_write_data, 32'h0);
    chk("t2_rw_rel", 32'(master_read_write), 32'h1);
    master_ready_ = 1'b1;

    // 3: grant withheld ten cycles, ready ignored meanwhile
    cpu_request = 1'b1;
    cpu_read_write = 1'b1;
    cpu_address = 30'h2AA;
    step();
    cpu_request = 1'b0;
    master_ready_ = 1'b0;
    master_read_data = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_req", 32'(master_request_), 32'h0);
      chk("t3_stb", 32'(master_address_strobe_), 32'h1);
      chk("t3_done", 32'({cpu_done, cpu_error}), 32'h0);
    end
    master_grant_ = 1'b0;
    step();
    chk("t3_stb_go", 32'(master_address_strobe_), 32'h0);
    chk("t3_addr", 32'(master_address), 32'h2AA);
    step();
    chk("t3_done_go", 32'(cpu_done), 32'h1);
    chk("t3_err", 32'(cpu_error), 32'h0);
    chk("t3_rd", cpu_read_data, 32'h0BADF00D);
    master_grant_ = 1'b1;
    master_ready_ = 1'b1;

    // 4: timeout abort, then a normal read
    cpu_request = 1'b1;
    cpu_address = 30'h3;
    step();
    cpu_request = 1'b0;
    master_grant_ = 1'b0;
    master_read_data = 32'h11111111;
    step();
    chk("t4_stb", 32'(master_address_strobe_), 32'h0);
    master_grant_ = 1'b1;
    step();
    chk("t4_w2", 32'(cpu_done), 32'h0);
    step();
    chk("t4_w3", 32'(cpu_done), 32'h0);
    step();
    chk("t4_w4", 32'(cpu_done), 32'h0);
    chk("t4_busy_w4", 32'(cpu_busy), 32'h1);
    step();
    chk("t4_done", 32'(cpu_done), 32'h1);
    chk("t4_err", 32'(cpu_error), 32'h1);
    chk("t4_rd_keep", cpu_read_data, 32'h0BADF00D);
    chk("t4_busy", 32'(cpu_busy), 32'h0);
    chk("t4_req", 32'(master_request_), 32'h1);
    step();
    chk("t4_pulse", 32'({cpu_done, cpu_error}), 32'h0);
    cpu_request = 1'b1;
    cpu_address = 30'h4;
    step();
    cpu_request = 1'b0;
    master_grant_ = 1'b0;
    step();
    master_ready_ = 1'b0;
    master_read_data = 32'hCAFEF00D;
    step();
    chk("t4b_done", 32'(cpu_done), 32'h1);
    chk("t4b_err", 32'(cpu_error), 32'h0);
    chk("t4b_rd", cpu_read_data, 32'hCAFEF00D);
    master_grant_ = 1'b1;
    master_ready_ = 1'b1;

    // 5: reset in WAIT, then requests during busy
    cpu_request = 1'b1;
    cpu_address = 30'h5;
    step();
    chk("t5_busy", 32'(cpu_busy), 32'h1);
    cpu_address = 30'h7;
    master_grant_ = 1'b0;
    step();
    chk("t5_addr", 32'(master_address), 32'h5);
    master_grant_ = 1'b1;
    step();
    chk("t5_addr_w", 32'(master_address), 32'h5);
    chk("t5_busy_w", 32'(cpu_busy), 32'h1);
    reset = 1'b1;
    step();
    chk("t5_req", 32'(master_request_), 32'h1);
    chk("t5_stb", 32'(master_address_strobe_), 32'h1);
    chk("t5_busy_r", 32'(cpu_busy), 32'h0);
    chk("t5_done_r", 32'({cpu_done, cpu_error}), 32'h0);
    chk("t5_addr_r", 32'(master_address), 32'h0);
    chk("t5_rd_r", cpu_read_data, 32'h0);
    cpu_request = 1'b0;
    reset = 1'b0;
    step();
    chk("t5_done_after", 32'(cpu_done), 32'h0);
    chk("t5_busy_after", 32'(cpu_busy), 32'h0);

    cpu_request = 1'b1;
    cpu_address = 30'h9;
    step();
    chk("t5b_busy", 32'(cpu_busy), 32'h1);
    cpu_request = 1'b0;
    step();
    cpu_request = 1'b1;
    cpu_address = 30'h1F;
    step();
    cpu_request = 1'b0;
    master_grant_ = 1'b0;
    step();
    chk("t5b_addr", 32'(master_address), 32'h9);
    master_ready_ = 1'b0;
    master_read_data = 32'h0000900D;
    cpu_request = 1'b1;
    step();
    chk("t5b_done", 32'(cpu_done), 32'h1);
    chk("t5b_rd", cpu_read_data, 32'h0000900D);
    cpu_request = 1'b0;
    master_grant_ = 1'b1;
    master_ready_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      dones += int'(cpu_done);
    end
    chk("t5b_extra_done", 32'(dones), 32'h0);
    chk("t5b_idle_busy", 32'(cpu_busy), 32'h0);
    chk("t5b_idle_req", 32'(master_request_), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
